hpdcache_mem_read_responder: RTL and testbench

Memory-side responder for HPDcache refill (miss) read requests. Accepts one burst read request at a time, reads consecutive beats from a single-port backing array with fixed one-cycle read latency, and returns them to the cache with the request ID and a last-beat flag. A two-entry output FIFO with credit-based issue absorbs response back-pressure without dropping array data. It is the responder end of the cache's miss-request channel and is used in the standalone test harness and the FPGA memory model.

---
 rtl/hpdcache_mem_read_responder.sv | 207 ++++++++++++++++++++
 tb/tb_hpdcache_mem_read_responder.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_mem_read_responder.sv
// Memory-side responder for HPDcache refill reads: serves one burst at a time from a
// single-port array with one-cycle read latency, through a two-entry credit-managed FIFO.
module hpdcache_mem_read_responder #(
    parameter int unsigned PA_WIDTH       = 49,
    parameter int unsigned BEAT_WIDTH     = 256,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned LEN_WIDTH      = 3,
    parameter int unsigned ARR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [PA_WIDTH-1:0]       req_addr_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic [ID_WIDTH-1:0]       req_id_i,

    output logic                      arr_req_o,
    output logic [ARR_ADDR_WIDTH-1:0] arr_addr_o,
    input  logic [BEAT_WIDTH-1:0]     arr_rdata_i,

    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [BEAT_WIDTH-1:0]     resp_data_o,
    output logic [ID_WIDTH-1:0]       resp_id_o,
    output logic                      resp_last_o,
    output logic                      resp_error_o
);

    localparam int unsigned BEAT_BYTES = BEAT_WIDTH / 8;
    localparam int unsigned OFF_BITS   = $clog2(BEAT_BYTES);
    localparam int unsigned CNT_WIDTH  = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [ARR_ADDR_WIDTH-1:0] beat_idx_q, beat_idx_d;
    logic [CNT_WIDTH-1:0]      issue_left_q, issue_left_d;
    logic                      inflight_q, inflight_d;
    logic                      inflight_last_q, inflight_last_d;

    logic [BEAT_WIDTH-1:0]     fifo_data_q [2];
    logic [BEAT_WIDTH-1:0]     fifo_data_d [2];
    logic [1:0]                fifo_last_q, fifo_last_d;
    logic                      fifo_wptr_q, fifo_wptr_d;
    logic                      fifo_rptr_q, fifo_rptr_d;
    logic [1:0]                fifo_cnt_q, fifo_cnt_d;

    logic                      req_fire;
    logic                      req_aligned;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      last_pop;
    logic [2:0]                occ_after;
    logic                      issue_en;

    // Address bits above the array index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[PA_WIDTH-1:OFF_BITS+ARR_ADDR_WIDTH];

    always_comb begin
        req_fire    = req_valid_i && (state_q == ST_IDLE) && !rst_i;
        req_aligned = (req_addr_i[OFF_BITS-1:0] == '0);
        fifo_push   = inflight_q;
        fifo_pop    = (state_q == ST_BURST) && (fifo_cnt_q != 2'd0) && resp_ready_i;
        last_pop    = fifo_pop && fifo_last_q[fifo_rptr_q];
        // A slot freed by this cycle's pop may be reused by this cycle's issue.
        occ_after   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, fifo_pop};
        issue_en    = (state_q == ST_BURST) && (issue_left_q != '0) && (occ_after < 3'd2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    state_d = req_aligned ? ST_BURST : ST_ERR;
                end
            end
            ST_BURST: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        arr_req_o    = 1'b0;
        arr_addr_o   = beat_idx_q;
        resp_valid_o = 1'b0;
        resp_data_o  = '0;
        resp_id_o    = '0;
        resp_last_o  = 1'b0;
        resp_error_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = !rst_i;
            end
            ST_BURST: begin
                arr_req_o = issue_en;
                if (fifo_cnt_q != 2'd0) begin
                    resp_valid_o = 1'b1;
                    resp_data_o  = fifo_data_q[fifo_rptr_q];
                    resp_id_o    = id_q;
                    resp_last_o  = fifo_last_q[fifo_rptr_q];
                end
            end
            ST_ERR: begin
                resp_valid_o = 1'b1;
                resp_id_o    = id_q;
                resp_last_o  = 1'b1;
                resp_error_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        id_d            = id_q;
        beat_idx_d      = beat_idx_q;
        issue_left_d    = issue_left_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        fifo_wptr_d     = fifo_wptr_q;
        fifo_rptr_d     = fifo_rptr_q;

        if (req_fire) begin
            id_d         = req_id_i;
            beat_idx_d   = req_addr_i[OFF_BITS +: ARR_ADDR_WIDTH];
            issue_left_d = req_aligned ? ({1'b0, req_len_i} + CNT_WIDTH'(1)) : '0;
        end

        if (issue_en) begin
            beat_idx_d      = beat_idx_q + ARR_ADDR_WIDTH'(1);
            issue_left_d    = issue_left_q - CNT_WIDTH'(1);
            inflight_d      = 1'b1;
            inflight_last_d = (issue_left_q == CNT_WIDTH'(1));
        end

        // Array data is valid exactly one cycle after its issue and is always captured.
        if (fifo_push) begin
            fifo_data_d[fifo_wptr_q] = arr_rdata_i;
            fifo_last_d[fifo_wptr_q] = inflight_last_q;
            fifo_wptr_d              = ~fifo_wptr_q;
        end

        if (fifo_pop) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end

        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q            <= '0;
            beat_idx_q      <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_last_q     <= '0;
            fifo_wptr_q     <= 1'b0;
            fifo_rptr_q     <= 1'b0;
            fifo_cnt_q      <= 2'd0;
        end else begin
            id_q            <= id_d;
            beat_idx_q      <= beat_idx_d;
            issue_left_q    <= issue_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_last_q     <= fifo_last_d;
            fifo_wptr_q     <= fifo_wptr_d;
            fifo_rptr_q     <= fifo_rptr_d;
            fifo_cnt_q      <= fifo_cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk_i) begin
        fifo_data_q <= fifo_data_d;
    end

endmodule

// File: tb/tb_hpdcache_mem_read_responder.sv
// Bench for hpdcache_mem_read_responder: randomized bursts checked against a queue of
// expected beats derived from the request address, length and ID.
module tb_hpdcache_mem_read_responder;
    localparam int PA_WIDTH       = 49;
    localparam int BEAT_WIDTH     = 256;
    localparam int ID_WIDTH       = 4;
    localparam int LEN_WIDTH      = 3;
    localparam int ARR_ADDR_WIDTH = 12;
    localparam int OFF_BITS       = 5;
    localparam int NUM_WORDS      = BEAT_WIDTH / 32;

    typedef struct packed {
        logic [BEAT_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic                  last;
        logic                  err;
    } beat_t;

    logic                      clk_i = 1'b0;
    logic                      rst_i = 1'b1;
    logic                      req_valid_i = 1'b0;
    logic                      req_ready_o;
    logic [PA_WIDTH-1:0]       req_addr_i = '0;
    logic [LEN_WIDTH-1:0]      req_len_i = '0;
    logic [ID_WIDTH-1:0]       req_id_i = '0;
    logic                      arr_req_o;
    logic [ARR_ADDR_WIDTH-1:0] arr_addr_o;
    logic [BEAT_WIDTH-1:0]     arr_rdata_i;
    logic                      resp_valid_o;
    logic                      resp_ready_i = 1'b0;
    logic [BEAT_WIDTH-1:0]     resp_data_o;
    logic [ID_WIDTH-1:0]       resp_id_o;
    logic                      resp_last_o;
    logic                      resp_error_o;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    logic [31:0] mem_seed     = 32'h1234_5678;
    beat_t       exp_q[$];

    hpdcache_mem_read_responder #(
        .PA_WIDTH(PA_WIDTH), .BEAT_WIDTH(BEAT_WIDTH), .ID_WIDTH(ID_WIDTH),
        .LEN_WIDTH(LEN_WIDTH), .ARR_ADDR_WIDTH(ARR_ADDR_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_len_i(req_len_i), .req_id_i(req_id_i),
        .arr_req_o(arr_req_o), .arr_addr_o(arr_addr_o), .arr_rdata_i(arr_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_id_o(resp_id_o), .resp_last_o(resp_last_o), .resp_error_o(resp_error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [BEAT_WIDTH-1:0] mem_word(input logic [ARR_ADDR_WIDTH-1:0] idx);
        logic [BEAT_WIDTH-1:0] w;
        for (int k = 0; k < NUM_WORDS; k++)
            w[k*32 +: 32] = {idx, 4'(k), 16'h5A3C} ^ (mem_seed + 32'(k) * 32'h9E37_79B9);
        return w;
    endfunction

    // Backing array: one-cycle read latency, junk on the bus when not read.
    always @(posedge clk_i) begin
        if (arr_req_o) arr_rdata_i <= mem_word(arr_addr_o);
        else           arr_rdata_i <= {NUM_WORDS{$urandom}};
    end

    function automatic void model_request(input logic [PA_WIDTH-1:0] addr, input int len,
                                          input logic [ID_WIDTH-1:0] id);
        beat_t b;
        if (addr[OFF_BITS-1:0] != '0) begin
            b.data = '0; b.id = id; b.last = 1'b1; b.err = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k <= len; k++) begin
                b.data = mem_word(ARR_ADDR_WIDTH'(int'(addr[OFF_BITS +: ARR_ADDR_WIDTH]) + k));
                b.id   = id;
                b.last = (k == len);
                b.err  = 1'b0;
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic logic [PA_WIDTH-1:0] rand_addr(input bit aligned);
        logic [PA_WIDTH-1:0] a;
        a = PA_WIDTH'({$urandom, $urandom});
        if (aligned) a[OFF_BITS-1:0] = '0;
        else         a[OFF_BITS-1:0] = OFF_BITS'($urandom_range(31, 1));
        return a;
    endfunction

    // Entered just after a negedge; returns just after the negedge following acceptance.
    task automatic send_req(input logic [PA_WIDTH-1:0] addr, input int len,
                            input logic [ID_WIDTH-1:0] id, output int t_acc);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_len_i   = LEN_WIDTH'(len);
        req_id_i    = id;
        t_acc       = -1;
        for (int i = 0; i < 40 && t_acc < 0; i++) begin
            #1;
            if (req_ready_o) t_acc = cyc;
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        req_addr_i  = PA_WIDTH'({$urandom, $urandom});
        req_id_i    = ID_WIDTH'($urandom);
        if (t_acc >= 0) model_request(addr, len, id);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 1'b0; resp_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        tests_run++;
        if (req_ready_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready_during: req_ready_o=%0b expected 0", req_ready_o);
        end
        rst_i = 1'b0;
        #1;
        tests_run++;
        if ({req_ready_o, resp_valid_o, arr_req_o, resp_last_o, resp_error_o} !== 5'b10000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: ready/valid/arr/last/err=%b expected 10000",
                     {req_ready_o, resp_valid_o, arr_req_o, resp_last_o, resp_error_o});
        end
        tests_run++;
        if (resp_data_o !== '0 || resp_id_o !== '0 || arr_addr_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: data=%h id=%0d arr_addr=%0h expected all 0",
                     resp_data_o, resp_id_o, arr_addr_o);
        end
        @(negedge clk_i);
        for (int i = 0; i < 10; i++) begin
            resp_ready_i = 1'($urandom);
            #1;
            tests_run++;
            if (arr_req_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL idle_quiet: arr_req=%0b resp_valid=%0b req_ready=%0b expected 0 0 1",
                         arr_req_o, resp_valid_o, req_ready_o);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_aligned_burst();
        int t_acc, t_first, t_last, t_ready, guard;
        logic [ARR_ADDR_WIDTH-1:0] addrs[$];
        int icyc[$];
        beat_t got, exp;
        resp_ready_i = 1'b1;
        send_req(49'h40, 3, 4'd5, t_acc);
        tests_run++;
        if (t_acc < 0) begin
            tests_failed++;
            $display("[TB] FAIL aligned_accept: request not accepted within 40 cycles");
            return;
        end
        t_first = -1; t_last = -1; t_ready = -1; guard = 0;
        while (t_ready < 0 && guard < 30) begin
            #1;
            if (arr_req_o) begin addrs.push_back(arr_addr_o); icyc.push_back(cyc); end
            if (resp_valid_o && t_first < 0) t_first = cyc;
            if (t_last >= 0 && req_ready_o) t_ready = cyc;
            if (resp_valid_o && resp_ready_i) begin
                got = {resp_data_o, resp_id_o, resp_last_o, resp_error_o};
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL aligned_beat: unexpected extra beat id=%0d", resp_id_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        tests_failed++;
                        $display("[TB] FAIL aligned_beat: got data=%h id=%0d last=%0b err=%0b, expected data=%h id=%0d last=%0b err=%0b",
                                 got.data, got.id, got.last, got.err, exp.data, exp.id, exp.last, exp.err);
                    end
                end
                if (resp_last_o) t_last = cyc;
            end
            @(negedge clk_i);
            guard++;
        end
        tests_run++;
        if (addrs.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL aligned_issue_count: got %0d reads, expected 4", addrs.size());
        end
        for (int i = 0; i < addrs.size() && i < 4; i++) begin
            tests_run++;
            if (addrs[i] !== ARR_ADDR_WIDTH'(2 + i) || icyc[i] != t_acc + 1 + i) begin
                tests_failed++;
                $display("[TB] FAIL aligned_issue: read %0d addr=%0h at T+%0d, expected addr=%0h at T+%0d",
                         i, addrs[i], icyc[i] - t_acc, 2 + i, 1 + i);
            end
        end
        tests_run++;
        if (t_first != t_acc + 3 || t_last != t_acc + 6 || t_ready != t_acc + 7) begin
            tests_failed++;
            $display("[TB] FAIL aligned_timing: first/last/ready at T+%0d/T+%0d/T+%0d, expected T+3/T+6/T+7",
                     t_first - t_acc, t_last - t_acc, t_ready - t_acc);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL aligned_complete: %0d beats missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_pressure();
        int t_acc, guard, issued, popped, stall, outstanding;
        logic prev_hold;
        beat_t prev, got, exp;
        resp_ready_i = 1'b1;
        send_req(rand_addr(1'b1), 7, ID_WIDTH'($urandom), t_acc);
        tests_run++;
        if (t_acc < 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept: request not accepted within 40 cycles");
            return;
        end
        issued = 0; popped = 0; stall = 0; prev_hold = 1'b0; guard = 0; prev = '0;
        while (popped < 8 && guard < 60) begin
            if (popped == 1 && stall < 5) begin resp_ready_i = 1'b0; stall++; end
            else resp_ready_i = 1'b1;
            #1;
            if (arr_req_o) issued++;
            got = {resp_data_o, resp_id_o, resp_last_o, resp_error_o};
            if (prev_hold) begin
                tests_run++;
                if (resp_valid_o !== 1'b1 || got !== prev) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_hold: valid=%0b data=%h, expected valid=1 data=%h",
                             resp_valid_o, got.data, prev.data);
                end
            end
            outstanding = issued - popped - ((resp_valid_o && resp_ready_i) ? 1 : 0);
            tests_run++;
            if (outstanding > 2) begin
                tests_failed++;
                $display("[TB] FAIL bp_credit: %0d beats outstanding, expected at most 2", outstanding);
            end
            if (resp_valid_o && resp_ready_i) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_beat: unexpected extra beat id=%0d", resp_id_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        tests_failed++;
                        $display("[TB] FAIL bp_beat: got data=%h id=%0d last=%0b, expected data=%h id=%0d last=%0b",
                                 got.data, got.id, got.last, exp.data, exp.id, exp.last);
                    end
                end
                popped++;
            end
            prev_hold = resp_valid_o && !resp_ready_i;
            prev = got;
            @(negedge clk_i);
            guard++;
        end
        tests_run++;
        if (popped != 8 || issued != 8 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_complete: popped=%0d issued=%0d left=%0d, expected 8 8 0",
                     popped, issued, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_misaligned();
        int t_acc, t_first, popped, arr_seen, guard;
        beat_t got, exp;
        resp_ready_i = 1'b0;
        send_req(49'h44, 0, 4'd9, t_acc);
        tests_run++;
        if (t_acc < 0) begin
            tests_failed++;
            $display("[TB] FAIL mis_accept: request not accepted within 40 cycles");
            return;
        end
        t_first = -1; popped = 0; arr_seen = 0; guard = 0;
        while (popped == 0 && guard < 20) begin
            resp_ready_i = (guard >= 2);
            #1;
            if (arr_req_o) arr_seen++;
            if (resp_valid_o && t_first < 0) t_first = cyc;
            if (resp_valid_o && resp_ready_i) begin
                got = {resp_data_o, resp_id_o, resp_last_o, resp_error_o};
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL mis_beat: got data=%h id=%0d last=%0b err=%0b, expected data=0 id=9 last=1 err=1",
                             got.data, got.id, got.last, got.err);
                end
                popped++;
            end
            @(negedge clk_i);
            guard++;
        end
        tests_run++;
        if (t_first != t_acc + 1 || arr_seen != 0 || popped != 1) begin
            tests_failed++;
            $display("[TB] FAIL mis_flow: first valid T+%0d reads=%0d beats=%0d, expected T+1 0 1",
                     t_first - t_acc, arr_seen, popped);
        end
        #1;
        tests_run++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mis_return: req_ready=%0b resp_valid=%0b, expected 1 0", req_ready_o, resp_valid_o);
        end
        @(negedge clk_i);
        exp_q.delete();
    endtask

    task automatic test_wrap_around();
        int t_acc, guard;
        logic [ARR_ADDR_WIDTH-1:0] addrs[$];
        beat_t got, exp;
        resp_ready_i = 1'b1;
        send_req({32'($urandom), 12'hFFF, 5'b0}, 1, ID_WIDTH'($urandom), t_acc);
        tests_run++;
        if (t_acc < 0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_accept: request not accepted within 40 cycles");
            return;
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            #1;
            if (arr_req_o) addrs.push_back(arr_addr_o);
            if (resp_valid_o && resp_ready_i) begin
                got = {resp_data_o, resp_id_o, resp_last_o, resp_error_o};
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_beat: got data=%h id=%0d last=%0b, expected data=%h id=%0d last=%0b",
                             got.data, got.id, got.last, exp.data, exp.id, exp.last);
                end
            end
            @(negedge clk_i);
            guard++;
        end
        tests_run++;
        if (addrs.size() != 2 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_count: reads=%0d beats left=%0d, expected 2 0", addrs.size(), exp_q.size());
        end else begin
            tests_run++;
            if (addrs[0] !== 12'hFFF || addrs[1] !== 12'h000) begin
                tests_failed++;
                $display("[TB] FAIL wrap_addr: got %h,%h expected fff,000", addrs[0], addrs[1]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int t_acc, guard, popped;
        beat_t got, exp;
        resp_ready_i = 1'b1;
        send_req(rand_addr(1'b1), 7, ID_WIDTH'($urandom), t_acc);
        tests_run++;
        if (t_acc < 0) begin
            tests_failed++;
            $display("[TB] FAIL rst_accept: request not accepted within 40 cycles");
            return;
        end
        popped = 0; guard = 0;
        while (popped < 2 && guard < 30) begin
            #1;
            if (resp_valid_o && resp_ready_i) begin
                got = {resp_data_o, resp_id_o, resp_last_o, resp_error_o};
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL rst_pre_beat: got data=%h id=%0d, expected data=%h id=%0d",
                             got.data, got.id, exp.data, exp.id);
                end
                popped++;
            end
            @(negedge clk_i);
            guard++;
        end
        #1;
        tests_run++;
        if (resp_valid_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_third_beat: resp_valid=%0b expected 1", resp_valid_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        tests_run++;
        if ({resp_valid_o, arr_req_o, req_ready_o, resp_last_o} !== 4'b0010 ||
            resp_data_o !== '0 || resp_id_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rst_flush: valid/arr/ready/last=%b data=%h id=%0d, expected 0010 0 0",
                     {resp_valid_o, arr_req_o, req_ready_o, resp_last_o}, resp_data_o, resp_id_o);
        end
        exp_q.delete();
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            resp_ready_i = 1'($urandom);
            #1;
            tests_run++;
            if (resp_valid_o !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rst_leftover: resp_valid=%0b expected 0", resp_valid_o);
            end
            @(negedge clk_i);
        end
        resp_ready_i = 1'b1;
        send_req(rand_addr(1'b1), $urandom_range(0, 7), ID_WIDTH'($urandom), t_acc);
        tests_run++;
        if (t_acc < 0) begin
            tests_failed++;
            $display("[TB] FAIL rst_new_accept: request not accepted within 40 cycles");
            return;
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            #1;
            if (resp_valid_o && resp_ready_i) begin
                got = {resp_data_o, resp_id_o, resp_last_o, resp_error_o};
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL rst_new_beat: got data=%h id=%0d last=%0b, expected data=%h id=%0d last=%0b",
                             got.data, got.id, got.last, exp.data, exp.id, exp.last);
                end
            end
            @(negedge clk_i);
            guard++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL rst_new_complete: %0d beats missing, expected 0", exp_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (resp_valid_o !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rst_new_extra: resp_valid=%0b expected 0", resp_valid_o);
            end
            @(negedge clk_i);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int t_acc, guard, len;
        bit aligned;
        logic [PA_WIDTH-1:0] addr;
        beat_t got, exp;
        for (int r = 0; r < 12; r++) begin
            aligned      = ($urandom_range(0, 3) != 0);
            addr         = rand_addr(aligned);
            len          = $urandom_range(0, 7);
            resp_ready_i = 1'($urandom);
            send_req(addr, len, ID_WIDTH'($urandom), t_acc);
            tests_run++;
            if (t_acc < 0) begin
                tests_failed++;
                $display("[TB] FAIL rand_accept: request %0d not accepted within 40 cycles", r);
                exp_q.delete();
                continue;
            end
            guard = 0;
            while (exp_q.size() > 0 && guard < 100) begin
                resp_ready_i = ($urandom_range(0, 9) < 7);
                #1;
                if (resp_valid_o && resp_ready_i) begin
                    got = {resp_data_o, resp_id_o, resp_last_o, resp_error_o};
                    exp = exp_q.pop_front();
                    tests_run++;
                    if (got !== exp) begin
                        tests_failed++;
                        $display("[TB] FAIL rand_beat: req %0d got data=%h id=%0d last=%0b err=%0b, expected data=%h id=%0d last=%0b err=%0b",
                                 r, got.data, got.id, got.last, got.err, exp.data, exp.id, exp.last, exp.err);
                    end
                end
                @(negedge clk_i);
                guard++;
            end
            tests_run++;
            if (exp_q.size() != 0) begin
                tests_failed++;
                $display("[TB] FAIL rand_complete: req %0d has %0d beats missing, expected 0", r, exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    initial begin
        mem_seed = $urandom;
        test_reset();
        test_aligned_burst();
        test_back_pressure();
        test_misaligned();
        test_wrap_around();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
